wb_stage: RTL and testbench

//  Write-back stage: the write side of the register-file port in the ID stage.
//  - Accepts completed results from EX/MEM over a valid/ready handshake and buffers them in a FIFO.
//  - Drives reg_write_wb / rd_wb / regfile_data_in, at most one register write per cycle.
//  - Keeps a per-register pending-write scoreboard so ID can detect RAW hazards on rs1/rs2.

---
 rtl/wb_stage_if.sv | 50 +++++
 rtl/wb_stage.sv | 166 ++++++++++++++++
 tb/tb_wb_stage.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Result, issue, query and register-file write signals of the write-back stage.
// WB_FWD_EN adds the forwarding lookup outputs.
interface wb_stage_if;
    logic        res_valid;
    logic        res_ready;
    logic        res_reg_write;
    logic [3:0]  res_rd;
    logic [15:0] res_data;

    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_ready;

    logic [3:0]  q_rs1;
    logic [3:0]  q_rs2;
    logic        busy_rs1;
    logic        busy_rs2;

    logic        reg_write_wb;
    logic [3:0]  rd_wb;
    logic [15:0] regfile_data_in;

`ifdef WB_FWD_EN
    logic        fwd_rs1_hit;
    logic        fwd_rs2_hit;
    logic [15:0] fwd_rs1_data;
    logic [15:0] fwd_rs2_data;
`endif

    // Pipeline side: EX/MEM drives results, ID drives issues and queries.
    modport master (
        output res_valid, res_reg_write, res_rd, res_data,
        output iss_valid, iss_rd, q_rs1, q_rs2,
        input  res_ready, iss_ready, busy_rs1, busy_rs2,
        input  reg_write_wb, rd_wb, regfile_data_in
`ifdef WB_FWD_EN
        , input fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
`endif
    );

    modport slave (
        input  res_valid, res_reg_write, res_rd, res_data,
        input  iss_valid, iss_rd, q_rs1, q_rs2,
        output res_ready, iss_ready, busy_rs1, busy_rs2,
        output reg_write_wb, rd_wb, regfile_data_in
`ifdef WB_FWD_EN
        , output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
`endif
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: result FIFO, register-file write port and pending-write scoreboard.
// Define WB_FWD_EN to add youngest-match forwarding from the FIFO and output register.
module wb_stage #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned SB_CNT_W = 2
) (
    input logic       clk,
    input logic       rst_n,
    wb_stage_if.slave wb
);
    localparam int unsigned         AW      = $clog2(DEPTH);
    localparam logic [AW:0]         PTR_ONE = (AW + 1)'(1);
    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

    typedef struct packed {
        logic        reg_write;
        logic [3:0]  rd;
        logic [15:0] data;
    } entry_t;

    entry_t              fifo_q [DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                full, empty, push, pop;
    entry_t              head;

    logic                reg_write_q;
    logic [3:0]          rd_q;
    logic [15:0]         data_q;

    logic [SB_CNT_W-1:0] cnt_q [16];
    logic [SB_CNT_W-1:0] cnt_d [16];
    logic                iss_fire;
    logic                inc, dec;

    // ---------------------------------------------------------------- result FIFO
    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = wb.res_valid && !full;
    assign pop   = !empty;
    assign head  = fifo_q[rd_ptr_q[AW-1:0]];

    assign wb.res_ready = !full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= '{reg_write: wb.res_reg_write,
                                          rd:        wb.res_rd,
                                          data:      wb.res_data};
        end
    end

    // ---------------------------------------------------------------- output register
    // Address and data hold when idle; only the write enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else if (pop) begin
            reg_write_q <= head.reg_write;
            rd_q        <= head.rd;
            data_q      <= head.data;
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    assign wb.reg_write_wb    = reg_write_q;
    assign wb.rd_wb           = rd_q;
    assign wb.regfile_data_in = data_q;

    // ---------------------------------------------------------------- scoreboard
    assign wb.iss_ready = (cnt_q[wb.iss_rd] != CNT_MAX);
    assign iss_fire     = wb.iss_valid && wb.iss_ready;

    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        for (int unsigned r = 0; r < 16; r++) begin
            inc      = iss_fire && (wb.iss_rd == 4'(r));
            dec      = reg_write_q && (rd_q == 4'(r));
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy drops at the regfile write edge, so a read after that sees the new value.
    assign wb.busy_rs1 = (cnt_q[wb.q_rs1] != '0);
    assign wb.busy_rs2 = (cnt_q[wb.q_rs2] != '0);

    sb_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(reg_write_q && (cnt_q[rd_q] == '0)))
        else $error("wb_stage: retiring rd=%0d with no pending write", rd_q);

    // ---------------------------------------------------------------- forwarding
`ifdef WB_FWD_EN
    logic [AW:0]    fill;
    logic [AW-1:0]  idx;
    logic           hit1, hit2;
    logic [15:0]    fwd1, fwd2;

    assign fill = wr_ptr_q - rd_ptr_q;

    // Walk oldest to newest so the youngest match wins; output register is lowest priority.
    always_comb begin
        idx  = '0;
        hit1 = reg_write_q && (rd_q == wb.q_rs1);
        hit2 = reg_write_q && (rd_q == wb.q_rs2);
        fwd1 = hit1 ? data_q : '0;
        fwd2 = hit2 ? data_q : '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q[AW-1:0] + AW'(i);
            if (((AW + 1)'(i) < fill) && fifo_q[idx].reg_write) begin
                if (fifo_q[idx].rd == wb.q_rs1) begin
                    hit1 = 1'b1;
                    fwd1 = fifo_q[idx].data;
                end
                if (fifo_q[idx].rd == wb.q_rs2) begin
                    hit2 = 1'b1;
                    fwd2 = fifo_q[idx].data;
                end
            end
        end
    end

    assign wb.fwd_rs1_hit  = hit1;
    assign wb.fwd_rs2_hit  = hit2;
    assign wb.fwd_rs1_data = fwd1;
    assign wb.fwd_rs2_data = fwd2;
`else
    // No lookup mux: ID resolves hazards from busy_rs1/busy_rs2 alone.
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a
// queue-based reference model. Define WB_FWD_EN to also check the forwarding outputs.
module tb_wb_stage;
    localparam int DEPTH    = 2;
    localparam int SB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << SB_CNT_W) - 1;

    typedef struct {
        bit        we;
        bit [3:0]  rd;
        bit [15:0] data;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    res_t      mq[$];
    bit        m_we;
    bit [3:0]  m_rd;
    bit [15:0] m_data;
    int        m_cnt[16];
    int        pend[16];
    bit        last_push;
    bit [3:0]  got_rd[$];

    always #5 clk = ~clk;

    wb_stage_if wb();

    wb_stage #(
        .DEPTH    (DEPTH),
        .SB_CNT_W (SB_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we      = 1'b0;
        m_rd      = '0;
        m_data    = '0;
        last_push = 1'b0;
        for (int r = 0; r < 16; r++) begin
            m_cnt[r] = 0;
            pend[r]  = 0;
        end
    endtask

`ifdef WB_FWD_EN
    function automatic void fwd_ref(input bit [3:0] rs, output bit hit, output bit [15:0] data);
        hit  = 1'b0;
        data = '0;
        if (m_we && m_rd == rs) begin
            hit  = 1'b1;
            data = m_data;
        end
        foreach (mq[i]) begin
            if (mq[i].we && mq[i].rd == rs) begin
                hit  = 1'b1;
                data = mq[i].data;
            end
        end
    endfunction
`endif

    task automatic check_outputs();
`ifdef WB_FWD_EN
        bit        h;
        bit [15:0] d;
`endif
        check("res_ready", 32'(wb.res_ready), 32'(mq.size() < DEPTH));
        check("iss_ready", 32'(wb.iss_ready), 32'(m_cnt[wb.iss_rd] != CNT_MAX));
        check("busy_rs1", 32'(wb.busy_rs1), 32'(m_cnt[wb.q_rs1] != 0));
        check("busy_rs2", 32'(wb.busy_rs2), 32'(m_cnt[wb.q_rs2] != 0));
        check("reg_write_wb", 32'(wb.reg_write_wb), 32'(m_we));
        check("rd_wb", 32'(wb.rd_wb), 32'(m_rd));
        check("regfile_data_in", 32'(wb.regfile_data_in), 32'(m_data));
`ifdef WB_FWD_EN
        fwd_ref(wb.q_rs1, h, d);
        check("fwd_rs1_hit", 32'(wb.fwd_rs1_hit), 32'(h));
        check("fwd_rs1_data", 32'(wb.fwd_rs1_data), 32'(d));
        fwd_ref(wb.q_rs2, h, d);
        check("fwd_rs2_hit", 32'(wb.fwd_rs2_hit), 32'(h));
        check("fwd_rs2_data", 32'(wb.fwd_rs2_data), 32'(d));
`endif
    endtask

    // Advance the model by one clock edge using the inputs presented before the edge.
    task automatic model_edge();
        bit   push, iss, same;
        res_t r;
        push = wb.res_valid && (mq.size() < DEPTH);
        iss  = wb.iss_valid && (m_cnt[wb.iss_rd] != CNT_MAX);
        same = iss && m_we && (m_rd == wb.iss_rd);
        if (iss) pend[wb.iss_rd]++;
        if (iss && !same) m_cnt[wb.iss_rd]++;
        if (m_we && !same && m_cnt[m_rd] > 0) m_cnt[m_rd]--;
        if (mq.size() > 0) begin
            r      = mq.pop_front();
            m_we   = r.we;
            m_rd   = r.rd;
            m_data = r.data;
        end else begin
            m_we = 1'b0;
        end
        if (push) begin
            r.we   = wb.res_reg_write;
            r.rd   = wb.res_rd;
            r.data = wb.res_data;
            mq.push_back(r);
        end
        last_push = push;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit rv, input bit rwe, input bit [3:0] rrd, input bit [15:0] rdat,
                         input bit iv, input bit [3:0] ird);
        wb.res_valid     = rv;
        wb.res_reg_write = rwe;
        wb.res_rd        = rrd;
        wb.res_data      = rdat;
        wb.iss_valid     = iv;
        wb.iss_rd        = ird;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Results only name registers with an outstanding recorded issue; held while stalled.
    task automatic rand_inputs();
        int cand[$];
        int r;
        if (!wb.res_valid || last_push) begin
            wb.res_valid     = ($urandom_range(0, 3) != 0);
            wb.res_data      = 16'($urandom);
            wb.res_reg_write = 1'b0;
            wb.res_rd        = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) if (pend[i] > 0) cand.push_back(i);
            if (wb.res_valid && cand.size() > 0 && $urandom_range(0, 4) != 0) begin
                r                = cand[$urandom_range(0, cand.size() - 1)];
                wb.res_reg_write = 1'b1;
                wb.res_rd        = 4'(r);
                pend[r]--;
            end
        end
        wb.iss_valid = 1'($urandom_range(0, 1));
        wb.iss_rd    = 4'($urandom_range(0, 5));
        wb.q_rs1     = 4'($urandom_range(0, 5));
        wb.q_rs2     = 4'($urandom_range(0, 5));
    endtask

    initial begin
        model_reset();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        wb.q_rs1 = 4'd0;
        wb.q_rs2 = 4'd0;

        // Reset held for three clocks
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_res_ready", 32'(wb.res_ready), 32'd1);
            check("rst_reg_write", 32'(wb.reg_write_wb), 32'd0);
            check("rst_rd_wb", 32'(wb.rd_wb), 32'd0);
            check("rst_data", 32'(wb.regfile_data_in), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single result rd=5 BEEF
        wb.q_rs1 = 4'd5;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5);
        cycle();
        drive(1'b1, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0);
        cycle();
        check("single_we_k", 32'(wb.reg_write_wb), 32'd0);
        check("single_busy_k", 32'(wb.busy_rs1), 32'd1);
        idle(1);
        check("single_we_k1", 32'(wb.reg_write_wb), 32'd1);
        check("single_rd_k1", 32'(wb.rd_wb), 32'd5);
        check("single_data_k1", 32'(wb.regfile_data_in), 32'hBEEF);
        idle(1);
        check("single_we_k2", 32'(wb.reg_write_wb), 32'd0);
        check("single_hold_data", 32'(wb.regfile_data_in), 32'hBEEF);
        check("single_busy_k2", 32'(wb.busy_rs1), 32'd0);

        // Three back-to-back results keep their order
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i));
            cycle();
        end
        got_rd.delete();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 4'(i), 16'(i * 16'h1111), 1'b0, 4'd0);
            for (int t = 0; t < 4 && !wb.res_ready; t++) cycle();
            cycle();
            if (wb.reg_write_wb) got_rd.push_back(wb.rd_wb);
        end
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (wb.reg_write_wb) got_rd.push_back(wb.rd_wb);
        end
        check("order_count", 32'(got_rd.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_rd.size()) check("order_rd", 32'(got_rd[i]), 32'(i + 1));
        end

        // Scoreboard: two writes of rd=3, then issue and retire on the same edge
        wb.q_rs1 = 4'd3;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3);
        cycle();
        cycle();
        drive(1'b1, 1'b1, 4'd3, 16'h0A0A, 1'b0, 4'd0);
        cycle();
        drive(1'b1, 1'b1, 4'd3, 16'h0B0B, 1'b0, 4'd0);
        cycle();
        idle(1);
        check("sb_busy_one_left", 32'(wb.busy_rs1), 32'd1);
        idle(1);
        check("sb_busy_clear", 32'(wb.busy_rs1), 32'd0);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3);
        cycle();
        drive(1'b1, 1'b1, 4'd3, 16'h0C0C, 1'b0, 4'd0);
        cycle();
        idle(1);
        check("sb_retire_we", 32'(wb.reg_write_wb), 32'd1);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3);
        cycle();
        check("sb_same_edge_busy", 32'(wb.busy_rs1), 32'd1);
        drive(1'b1, 1'b1, 4'd3, 16'h0D0D, 1'b0, 4'd0);
        cycle();
        idle(2);
        check("sb_same_edge_clear", 32'(wb.busy_rs1), 32'd0);

        // Saturation at three outstanding writes of rd=7
        wb.q_rs2 = 4'd7;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
        for (int i = 0; i < 3; i++) cycle();
        #1;
        check("sat_iss_ready", 32'(wb.iss_ready), 32'd0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 4'd7, 16'(16'h7000 + i), 1'b0, 4'd0);
            cycle();
        end
        idle(1);
        check("sat_busy_last", 32'(wb.busy_rs2), 32'd1);
        idle(1);
        check("sat_busy_clear", 32'(wb.busy_rs2), 32'd0);
        wb.iss_rd = 4'd7;
        #1;
        check("sat_iss_ready_back", 32'(wb.iss_ready), 32'd1);

`ifdef WB_FWD_EN
        // Two pending writes of rd=4: the newer value is forwarded
        wb.q_rs2 = 4'd4;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4);
        cycle();
        cycle();
        drive(1'b1, 1'b1, 4'd4, 16'h0011, 1'b0, 4'd0);
        cycle();
        drive(1'b1, 1'b1, 4'd4, 16'h0022, 1'b0, 4'd0);
        cycle();
        check("fwd_out_data", 32'(wb.regfile_data_in), 32'h0011);
        check("fwd_hit", 32'(wb.fwd_rs2_hit), 32'd1);
        check("fwd_youngest", 32'(wb.fwd_rs2_data), 32'h0022);
        idle(3);
        check("fwd_no_hit_data", 32'(wb.fwd_rs2_data), 32'd0);
`endif

        // Random traffic
        idle(2);
        for (int r = 0; r < 16; r++) pend[r] = 0;
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset with a write in the output register
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9);
        cycle();
        drive(1'b1, 1'b1, 4'd9, 16'h5A5A, 1'b0, 4'd0);
        cycle();
        idle(1);
        wb.q_rs1 = 4'd9;
        check("mid_we_before", 32'(wb.reg_write_wb), 32'd1);
        check("mid_rd_before", 32'(wb.rd_wb), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(wb.reg_write_wb), 32'd0);
        check("mid_rst_rd", 32'(wb.rd_wb), 32'd0);
        check("mid_rst_data", 32'(wb.regfile_data_in), 32'd0);
        check("mid_rst_ready", 32'(wb.res_ready), 32'd1);
        check("mid_rst_busy", 32'(wb.busy_rs1), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 100; n++) begin
            rand_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
